// File: rtl/fact_core_q_pkg.sv
// Shared definitions for the queued factorial core: register indices,
// controller states and STATUS bit positions.
package fact_core_q_pkg;

    // Register indices, taken from s_addr[5:3]
    localparam logic [2:0] REG_RUN      = 3'd0;
    localparam logic [2:0] REG_CLEAR    = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_INTREN   = 3'd3;
    localparam logic [2:0] REG_OPERAND  = 3'd4;
    localparam logic [2:0] REG_RESULT_H = 3'd5;
    localparam logic [2:0] REG_RESULT_L = 3'd6;
    localparam logic [2:0] REG_POP      = 3'd7;

    // Job controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    // STATUS bit positions
    localparam int STAT_VALID      = 0;
    localparam int STAT_BUSY       = 1;
    localparam int STAT_HEAD_OVF   = 2;
    localparam int STAT_DROP       = 3;
    localparam int STAT_OPCNT_LSB  = 8;
    localparam int STAT_RESCNT_LSB = 16;
    localparam int STAT_CNT_W      = 8;

endpackage

// File: rtl/fact_core_q_mul.sv
// Sequential shift-add multiplier: p = a * b, one multiplier bit per cycle.
// A start pulse loads the operands; done is high during the last of the OW
// working cycles, so p holds the full product from the following cycle on.
// A new start always reinitialises, so an abandoned run is harmless.
module mul_seq #(
    parameter int RW = 128,
    parameter int OW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RW-1:0]    a,
    input  logic [OW-1:0]    b,
    output logic             done,
    output logic [RW+OW-1:0] p
);

    localparam int CNTW = (OW > 1) ? $clog2(OW) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(OW - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic                running_reg;
    logic [CNTW-1:0]     cnt_reg;
    logic [RW+OW-1:0]    mcand_reg;
    logic [OW-1:0]       mplier_reg;
    logic [RW+OW-1:0]    p_reg;

    // Load operands on start, then add the shifted multiplicand per set bit
    always_ff @(posedge clk) begin
        if (reset) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            p_reg       <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= '0;
            mcand_reg   <= {{OW{1'b0}}, a};
            mplier_reg  <= b;
            p_reg       <= '0;
        end else if (running_reg) begin
            if (mplier_reg[0]) begin
                p_reg <= p_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_ONE;
            if (cnt_reg == CNT_LAST) begin
                running_reg <= 1'b0;
            end
        end
    end

    assign done = running_reg && (cnt_reg == CNT_LAST);
    assign p    = p_reg;

endmodule

// File: rtl/fact_core_q.sv
// Queued factorial core on the s_* register bus. Operands go into a small
// queue, a controller computes n! one multiply per k, and {ovf, result}
// entries land in a result FIFO that the host reads and pops.
module fact_core_q
    import fact_core_q_pkg::*;
#(
    parameter int DW     = 64,
    parameter int OW     = 8,
    parameter int RW     = 128,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_sel,
    input  logic          s_wr,
    input  logic [15:0]   s_addr,
    input  logic [DW-1:0] s_din,
    output logic [DW-1:0] s_dout,
    output logic          interrupt
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(QDEPTH);
    localparam logic [OW-1:0] K_ONE   = OW'(1);

    // Bus decode
    logic [2:0] idx;
    logic       wr_en;
    logic       clear;
    assign idx   = s_addr[5:3];
    assign wr_en = s_sel && s_wr;
    assign clear = wr_en && (idx == REG_CLEAR) && s_din[0];

    // Bits of the bus that carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{s_addr[15:6], s_addr[2:0], s_din[DW-1:OW]};

    // Control registers
    logic run_reg;
    logic intren_reg;
    logic drop_reg;

    // Operand queue
    logic [OW-1:0] op_mem [QDEPTH];
    logic [AW-1:0] op_wr_ptr_reg, op_rd_ptr_reg;
    logic [CW-1:0] op_count_reg;
    logic          op_empty, op_full, op_push, op_pop, drop_set;

    // Result FIFO, each entry {ovf, result}
    logic [RW:0]   res_mem [QDEPTH];
    logic [AW-1:0] res_wr_ptr_reg, res_rd_ptr_reg;
    logic [CW-1:0] res_count_reg;
    logic          res_empty, res_full, res_push, res_pop;
    logic [RW:0]   res_head;

    // Controller and datapath
    state_t           state_reg, state_next;
    logic [RW-1:0]    acc_reg;
    logic [OW-1:0]    k_reg, k_dec;
    logic             ovf_reg;
    logic             mul_start, mul_done;
    logic [RW-1:0]    mul_a;
    logic [OW-1:0]    mul_b;
    logic [RW+OW-1:0] mul_p;

    assign op_empty  = (op_count_reg == '0);
    assign op_full   = (op_count_reg == CNT_MAX);
    assign res_empty = (res_count_reg == '0);
    assign res_full  = (res_count_reg == CNT_MAX);
    assign k_dec     = k_reg - K_ONE;

    assign op_push  = wr_en && (idx == REG_OPERAND) && !clear && !op_full;
    assign drop_set = wr_en && (idx == REG_OPERAND) && !clear && op_full;
    assign res_pop  = wr_en && (idx == REG_POP) && !clear && !res_empty;

    // Run, interrupt-enable and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            run_reg    <= 1'b0;
            intren_reg <= 1'b0;
            drop_reg   <= 1'b0;
        end else begin
            if (wr_en && (idx == REG_RUN)) begin
                run_reg <= s_din[0];
            end
            if (wr_en && (idx == REG_INTREN)) begin
                intren_reg <= s_din[0];
            end
            if (clear) begin
                drop_reg <= 1'b0;
            end else if (drop_set) begin
                drop_reg <= 1'b1;
            end
        end
    end

    // Operand queue storage
    always_ff @(posedge clk) begin
        if (op_push) begin
            op_mem[op_wr_ptr_reg] <= s_din[OW-1:0];
        end
    end

    // Operand queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            op_wr_ptr_reg <= '0;
            op_rd_ptr_reg <= '0;
            op_count_reg  <= '0;
        end else begin
            if (op_push) op_wr_ptr_reg <= op_wr_ptr_reg + PTR_ONE;
            if (op_pop)  op_rd_ptr_reg <= op_rd_ptr_reg + PTR_ONE;
            if (op_push && !op_pop)      op_count_reg <= op_count_reg + CNT_ONE;
            else if (!op_push && op_pop) op_count_reg <= op_count_reg - CNT_ONE;
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr_reg] <= {ovf_reg, acc_reg};
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
            res_count_reg  <= '0;
        end else begin
            if (res_push) res_wr_ptr_reg <= res_wr_ptr_reg + PTR_ONE;
            if (res_pop)  res_rd_ptr_reg <= res_rd_ptr_reg + PTR_ONE;
            if (res_push && !res_pop)      res_count_reg <= res_count_reg + CNT_ONE;
            else if (!res_push && res_pop) res_count_reg <= res_count_reg - CNT_ONE;
        end
    end

    assign res_head = res_empty ? '0 : res_mem[res_rd_ptr_reg];

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Controller next state; CLEAR aborts whatever is in flight
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (run_reg && !op_empty) state_next = LOAD;
                LOAD:    state_next = (k_reg <= K_ONE) ? DONE : MUL;
                MUL:     if (mul_done) state_next = STEP;
                STEP:    state_next = (k_dec == K_ONE) ? DONE : MUL;
                DONE:    if (!res_full) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Controller outputs: dispatch, multiplier kick-off and result push
    always_comb begin
        op_pop    = 1'b0;
        mul_start = 1'b0;
        res_push  = 1'b0;
        if (!clear) begin
            case (state_reg)
                IDLE: op_pop    = run_reg && !op_empty;
                LOAD: mul_start = (k_reg > K_ONE);
                STEP: mul_start = (k_dec != K_ONE);
                DONE: res_push  = !res_full;
                default: ;
            endcase
        end
    end

    // On STEP the multiplier is restarted with the freshly truncated product
    // and k-1, the same values being committed to acc_reg/k_reg at that edge.
    assign mul_a = (state_reg == STEP) ? mul_p[RW-1:0] : acc_reg;
    assign mul_b = (state_reg == STEP) ? k_dec : k_reg;

    // Job datapath: load a new n, or fold in one finished product
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
            k_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (op_pop) begin
            acc_reg <= RW'(1);
            k_reg   <= op_mem[op_rd_ptr_reg];
            ovf_reg <= 1'b0;
        end else if ((state_reg == STEP) && !clear) begin
            acc_reg <= mul_p[RW-1:0];
            k_reg   <= k_dec;
            ovf_reg <= ovf_reg | (|mul_p[RW+OW-1:RW]);
        end
    end

    mul_seq #(
        .RW(RW),
        .OW(OW)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Head entry widened so both result halves can be sliced uniformly
    logic [2*DW-1:0] head_wide;
    always_comb begin
        head_wide         = '0;
        head_wide[RW-1:0] = res_head[RW-1:0];
    end

    // Register read mux; write-only and unselected reads give zero
    always_comb begin
        s_dout = '0;
        if (s_sel) begin
            case (idx)
                REG_RUN:    s_dout[0] = run_reg;
                REG_INTREN: s_dout[0] = intren_reg;
                REG_STATUS: begin
                    s_dout[STAT_VALID]    = !res_empty;
                    s_dout[STAT_BUSY]     = (state_reg != IDLE);
                    s_dout[STAT_HEAD_OVF] = res_head[RW];
                    s_dout[STAT_DROP]     = drop_reg;
                    s_dout[STAT_OPCNT_LSB  +: STAT_CNT_W] = STAT_CNT_W'(op_count_reg);
                    s_dout[STAT_RESCNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(res_count_reg);
                end
                REG_RESULT_H: s_dout = head_wide[2*DW-1:DW];
                REG_RESULT_L: s_dout = head_wide[DW-1:0];
                default:      s_dout = '0;
            endcase
        end
    end

    assign interrupt = intren_reg && !res_empty;

endmodule

// File: tb/tb_fact_core_q.sv
// Bench for fact_core_q: directed scenarios plus randomized job batches,
// each result checked against an arithmetic n! model mod 2^128.
module tb_fact_core_q;
    import fact_core_q_pkg::*;

    localparam int DW     = 64;
    localparam int OW     = 8;
    localparam int RW     = 128;
    localparam int QDEPTH = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          s_sel  = 1'b0;
    logic          s_wr   = 1'b0;
    logic [15:0]   s_addr = '0;
    logic [DW-1:0] s_din  = '0;
    logic [DW-1:0] s_dout;
    logic          interrupt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fact_core_q #(.DW(DW), .OW(OW), .RW(RW), .QDEPTH(QDEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // n! mod 2^128, with ovf set when the true value no longer fits
    function automatic void golden(input int n, output logic [127:0] acc, output logic ovf);
        logic [255:0] prod;
        acc = 128'd1;
        ovf = 1'b0;
        for (int k = n; k >= 2; k--) begin
            prod = {128'd0, acc} * 256'(k);
            if (prod[255:128] != '0) ovf = 1'b1;
            acc = prod[127:0];
        end
    endfunction

    function automatic int exp_lat(input int n);
        return (n <= 1) ? 2 : 2 + (n - 1) * (OW + 1);
    endfunction

    task automatic bus_write(input logic [2:0] idx, input logic [DW-1:0] data);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = {10'd0, idx, 3'd0}; s_din = data;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [DW-1:0] data);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = {10'd0, idx, 3'd0};
        #1;
        data  = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic pop_check(input logic [127:0] ea, input logic eo, input string tag);
        logic [DW-1:0] h, l, st;
        @(negedge clk);
        bus_read(REG_RESULT_L, l);
        bus_read(REG_RESULT_H, h);
        bus_read(REG_STATUS, st);
        $display("pop %s: got=0x%0h ovf=%0d exp=0x%0h ovf=%0d", tag, {h, l}, st[STAT_HEAD_OVF], ea, eo);
        chk({tag, " val"}, {h, l}, ea);
        chk({tag, " ovf"}, 128'(st[STAT_HEAD_OVF]), 128'(eo));
        bus_write(REG_POP, '0);
    endtask

    // Push one operand into an idle core with RUN=1 and time its result
    task automatic run_one(input int n, input bit do_pop);
        logic [DW-1:0] st;
        logic [127:0]  ea;
        logic          eo;
        int            c0;
        int            cyc;
        golden(n, ea, eo);
        @(negedge clk);
        bus_read(REG_STATUS, st);
        c0 = int'(st[23:16]);
        bus_write(REG_OPERAND, DW'(n));
        cyc = 0;
        bus_read(REG_STATUS, st);
        while (int'(st[23:16]) == c0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            bus_read(REG_STATUS, st);
        end
        $display("job n=%0d latency=%0d", n, cyc - 1);
        chk($sformatf("lat n=%0d", n), 128'(cyc - 1), 128'(exp_lat(n)));
        chk($sformatf("irq n=%0d", n), 128'(interrupt), 128'(1));
        if (do_pop) pop_check(ea, eo, $sformatf("n=%0d", n));
    endtask

    task automatic wait_results(input int target, input int budget);
        logic [DW-1:0] st;
        int cyc = 0;
        @(negedge clk);
        bus_read(REG_STATUS, st);
        while (int'(st[23:16]) != target && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus_read(REG_STATUS, st);
        end
        chk("wait results", 128'(st[23:16]), 128'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic [127:0]  ea;
        logic          eo;
        int            ops[$];
        int            n, k;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus_read(REG_STATUS, d);   chk("rst status", 128'(d), 128'(0));
        bus_read(REG_RUN, d);      chk("rst run", 128'(d), 128'(0));
        bus_read(REG_RESULT_L, d); chk("rst res_l", 128'(d), 128'(0));
        chk("rst irq", 128'(interrupt), 128'(0));

        // Test 1: 5! with interrupt enabled
        bus_write(REG_INTREN, 64'd1);
        bus_write(REG_RUN, 64'd1);
        bus_read(REG_RUN, d);      chk("run rd", 128'(d), 128'(1));
        bus_read(REG_CLEAR, d);    chk("wo clear rd", 128'(d), 128'(0));
        bus_read(REG_POP, d);      chk("wo pop rd", 128'(d), 128'(0));
        run_one(5, 1'b1);

        // Test 2: 0! and 1!, both kept then popped
        run_one(0, 1'b0);
        run_one(1, 1'b0);
        @(negedge clk);
        bus_read(REG_STATUS, d);   chk("t2 rescnt", 128'(d[23:16]), 128'(2));
        pop_check(128'd1, 1'b0, "n=0");
        pop_check(128'd1, 1'b0, "n=1");
        bus_read(REG_STATUS, d);   chk("t2 valid", 128'(d[STAT_VALID]), 128'(0));
        chk("t2 irq", 128'(interrupt), 128'(0));
        bus_write(REG_POP, '0);
        bus_read(REG_STATUS, d);   chk("t2 empty pop", 128'(d[23:16]), 128'(0));

        // Test 3: largest fitting factorial and first overflowing one
        run_one(34, 1'b1);
        run_one(35, 1'b1);

        // Test 4: queue overflow while stopped, then drain in order
        bus_write(REG_RUN, 64'd0);
        ops.delete();
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 12);
            if (i < QDEPTH) ops.push_back(n);
            bus_write(REG_OPERAND, DW'(n));
        end
        bus_read(REG_STATUS, d);
        chk("t4 opcnt", 128'(d[15:8]), 128'(4));
        chk("t4 drop", 128'(d[STAT_DROP]), 128'(1));
        bus_write(REG_RUN, 64'd1);
        wait_results(4, 2000);
        foreach (ops[i]) begin
            golden(ops[i], ea, eo);
            pop_check(ea, eo, $sformatf("t4 n=%0d", ops[i]));
        end
        bus_read(REG_STATUS, d);
        chk("t4 drop sticky", 128'(d[STAT_DROP]), 128'(1));

        // Test 5: CLEAR mid-job
        bus_write(REG_OPERAND, DW'(20));
        repeat (50) @(negedge clk);
        bus_write(REG_CLEAR, 64'd1);
        bus_read(REG_STATUS, d);
        chk("t5 busy", 128'(d[STAT_BUSY]), 128'(0));
        chk("t5 opcnt", 128'(d[15:8]), 128'(0));
        chk("t5 rescnt", 128'(d[23:16]), 128'(0));
        chk("t5 drop", 128'(d[STAT_DROP]), 128'(0));
        bus_read(REG_RUN, d);      chk("t5 run kept", 128'(d), 128'(1));
        repeat (250) @(negedge clk);
        bus_read(REG_STATUS, d);   chk("t5 no result", 128'(d[23:16]), 128'(0));

        // Randomized batches
        for (int r = 0; r < 6; r++) begin
            bus_write(REG_RUN, 64'd0);
            ops.delete();
            k = $urandom_range(1, QDEPTH);
            for (int i = 0; i < k; i++) begin
                n = $urandom_range(0, 60);
                ops.push_back(n);
                bus_write(REG_OPERAND, DW'(n));
            end
            bus_write(REG_RUN, 64'd1);
            wait_results(k, 3000);
            foreach (ops[i]) begin
                golden(ops[i], ea, eo);
                pop_check(ea, eo, $sformatf("rnd%0d n=%0d", r, ops[i]));
            end
        end

        // Test 6: full result FIFO stalls the fifth job in DONE
        bus_write(REG_RUN, 64'd0);
        for (int i = 2; i <= 5; i++) bus_write(REG_OPERAND, DW'(i));
        bus_write(REG_RUN, 64'd1);
        wait_results(4, 500);
        bus_write(REG_OPERAND, DW'(6));
        repeat (70) @(negedge clk);
        bus_read(REG_STATUS, d);
        chk("t6 stall busy", 128'(d[STAT_BUSY]), 128'(1));
        chk("t6 stall rescnt", 128'(d[23:16]), 128'(4));
        chk("t6 stall opcnt", 128'(d[15:8]), 128'(0));
        bus_read(REG_RESULT_L, d); chk("t6 head", 128'(d), 128'(2));
        bus_write(REG_POP, '0);
        bus_read(REG_STATUS, d);   chk("t6 after pop", 128'(d[23:16]), 128'(3));
        @(negedge clk);
        bus_read(REG_STATUS, d);
        chk("t6 pushed", 128'(d[23:16]), 128'(4));
        chk("t6 idle", 128'(d[STAT_BUSY]), 128'(0));
        pop_check(128'd6, 1'b0, "t6 n=3");
        pop_check(128'd24, 1'b0, "t6 n=4");
        pop_check(128'd120, 1'b0, "t6 n=5");
        pop_check(128'd720, 1'b0, "t6 n=6");

        // Reset in the middle of a job
        bus_write(REG_OPERAND, DW'(30));
        repeat (20) @(negedge clk);
        bus_read(REG_STATUS, d);   chk("t6 midjob busy", 128'(d[STAT_BUSY]), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_read(REG_STATUS, d);   chk("rst2 status", 128'(d), 128'(0));
        bus_read(REG_RUN, d);      chk("rst2 run", 128'(d), 128'(0));
        bus_read(REG_INTREN, d);   chk("rst2 intren", 128'(d), 128'(0));
        bus_read(REG_RESULT_L, d); chk("rst2 res_l", 128'(d), 128'(0));
        chk("rst2 irq", 128'(interrupt), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
